// File: rtl/mem_dma_master.sv
// Word-copy / word-fill DMA initiator on the picorv32 native memory handshake.
// Every access is followed by a one-cycle gap with mem_valid low.
module mem_dma_master #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             fill,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    input  logic [31:0]      fill_value,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [TW-1:0]    WAIT_ONE = TW'(1);
    localparam logic [TW-1:0]    WAIT_END = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_GAP = 3'd2,
        WR_REQ = 3'd3,
        WR_GAP = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d;
    logic [31:0]      data_q, data_d, fval_q, fval_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [TW-1:0]    wait_q, wait_d;
    logic             fill_q, fill_d, busy_q, busy_d, done_q, done_d;
    logic             error_q, error_d, valid_q, valid_d;
    logic             ack_s, timeout_s;

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign mem_valid = valid_q;
    assign mem_instr = 1'b0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    // Handshake qualifiers for the request currently on the bus
    always_comb begin
        ack_s     = valid_q && mem_ready;
        timeout_s = (TIMEOUT != 0) && valid_q && !mem_ready && (wait_q == WAIT_END);
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        fval_d  = fval_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rem_d   = rem_q;
        wstrb_d = wstrb_q;
        wait_d  = wait_q;
        fill_d  = fill_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr & 32'hFFFF_FFFC;
                    dst_d   = dst_addr & 32'hFFFF_FFFC;
                    rem_d   = len_words;
                    fill_d  = fill;
                    fval_d  = fill_value;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    wait_d  = {TW{1'b0}};
                    // A zero-length job passes through the end-of-word gap so it ends like any other
                    if (len_words == LEN_ZERO) begin
                        state_d = WR_GAP;
                    end else if (fill) begin
                        state_d = WR_REQ;
                        valid_d = 1'b1;
                        addr_d  = dst_addr & 32'hFFFF_FFFC;
                        wdata_d = fill_value;
                        wstrb_d = 4'b1111;
                    end else begin
                        state_d = RD_REQ;
                        valid_d = 1'b1;
                        addr_d  = src_addr & 32'hFFFF_FFFC;
                        wstrb_d = 4'b0000;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ, WR_REQ: begin
                if (ack_s) begin
                    valid_d = 1'b0;
                    if (state_q == RD_REQ) begin
                        data_d  = mem_rdata;
                        src_d   = src_q + 32'd4;
                        state_d = RD_GAP;
                    end else begin
                        dst_d   = dst_q + 32'd4;
                        rem_d   = rem_q - LEN_ONE;
                        state_d = WR_GAP;
                    end
                end else if (timeout_s) begin
                    valid_d = 1'b0;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            RD_GAP: begin
                state_d = WR_REQ;
                valid_d = 1'b1;
                addr_d  = dst_q;
                wdata_d = fill_q ? fval_q : data_q;
                wstrb_d = 4'b1111;
                wait_d  = {TW{1'b0}};
            end
            WR_GAP: begin
                wait_d = {TW{1'b0}};
                if (rem_q == LEN_ZERO) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else if (fill_q) begin
                    state_d = WR_REQ;
                    valid_d = 1'b1;
                    addr_d  = dst_q;
                    wdata_d = fval_q;
                    wstrb_d = 4'b1111;
                end else begin
                    state_d = RD_REQ;
                    valid_d = 1'b1;
                    addr_d  = src_q;
                    wstrb_d = 4'b0000;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            src_q   <= 32'd0;
            dst_q   <= 32'd0;
            data_q  <= 32'd0;
            fval_q  <= 32'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rem_q   <= {LEN_W{1'b0}};
            wstrb_q <= 4'b0000;
            wait_q  <= {TW{1'b0}};
            fill_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            fval_q  <= fval_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rem_q   <= rem_d;
            wstrb_q <= wstrb_d;
            wait_q  <= wait_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            valid_q <= valid_d;
        end
    end

endmodule
